// File: rtl/apb_pkg.sv
// Shared APB master types: FSM state encoding, bus widths and the latched request bundle.
package apb_pkg;

  localparam int APB_ADDR_W     = 32;
  localparam int APB_DATA_W     = 32;
  localparam int APB_MAX_SLAVES = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_decoder.sv
// Combinational slave decode: 4-bit index to one-hot PSEL, flagging indices beyond the populated slaves.
module apb_decoder
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 16
) (
  input  logic [3:0]                index,
  output logic [APB_MAX_SLAVES-1:0] psel,
  output logic                      decode_err
);

  always_comb begin
    psel       = '0;
    decode_err = (int'(index) >= NUM_SLAVES);
    if (!decode_err) psel[index] = 1'b1;
  end

endmodule

// File: rtl/apb_master.sv
// APB master bridge: valid/ready request -> SETUP -> ACCESS (PREADY waits) -> held response; 3-cycle zero-wait latency.
// One transfer in flight, new requests stall until the response is taken. Optional ACCESS timeout: APB_MASTER_TIMEOUT_EN.
module apb_master
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES     = 16,
  parameter int SEL_LSB        = 12,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      PCLK,
  input  logic                      PRESET,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [APB_ADDR_W-1:0]     req_addr,
  input  logic [APB_DATA_W-1:0]     req_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_W-1:0]     rsp_rdata,
  output logic                      rsp_err,
  output logic [APB_ADDR_W-1:0]     PADDR,
  output logic [APB_DATA_W-1:0]     PWDATA,
  output logic                      PWRITE,
  output logic [APB_MAX_SLAVES-1:0] PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_W-1:0]     PRDATA,
  input  logic                      PREADY
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > APB_MAX_SLAVES || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("apb_master: parameter out of range");
  end

  apb_state_t                state;
  apb_req_t                  req_in;
  logic [APB_MAX_SLAVES-1:0] dec_psel;
  logic                      dec_err;
  logic                      tmo_hit;

  assign req_in    = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  apb_decoder #(
    .NUM_SLAVES(NUM_SLAVES)
  ) u_decoder (
    .index     (req_in.addr[SEL_LSB+3:SEL_LSB]),
    .psel      (dec_psel),
    .decode_err(dec_err)
  );

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts stalled ACCESS cycles; the last allowed one aborts unless PREADY arrives with it.
  always_ff @(posedge PCLK) begin
    if (PRESET || state == SETUP) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !PREADY) begin
      tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign tmo_hit = (state == ACCESS) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (dec_err) begin
              // Unpopulated slave: answer directly, the bus stays quiet.
              state     <= RESP;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state  <= SETUP;
              PSEL   <= dec_psel;
              PADDR  <= req_in.addr;
              PWDATA <= req_in.wdata;
              PWRITE <= req_in.write;
            end
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (PREADY) begin
            state     <= RESP;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_rdata <= PWRITE ? '0 : PRDATA;
            rsp_err   <= 1'b0;
          end else if (tmo_hit) begin
            state     <= RESP;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: scoreboard queue of expected responses, popped by a negedge monitor.
module tb_apb_master;
  import apb_pkg::*;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b1;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, PWRITE, PENABLE;
  logic [31:0] rsp_rdata, PADDR, PWDATA;
  logic [15:0] PSEL;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;

  logic        s_req_valid = 1'b0;
  logic [31:0] s_req_addr = '0;
  logic        s_req_write = 1'b0, s_rsp_ready = 1'b1;
  logic [31:0] s_req_wdata = '0;
  logic        s_req_ready, s_rsp_valid, s_rsp_err, s_pwrite, s_penable;
  logic [31:0] s_rsp_rdata, s_paddr, s_pwdata;
  logic [15:0] s_psel;

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  apb_master #(.NUM_SLAVES(16), .SEL_LSB(12), .TIMEOUT_CYCLES(8)) u_dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  apb_master #(.NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT_CYCLES(8)) u_small (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
    .req_addr(s_req_addr), .req_wdata(s_req_wdata),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_rdata(s_rsp_rdata), .rsp_err(s_rsp_err),
    .PADDR(s_paddr), .PWDATA(s_pwdata), .PWRITE(s_pwrite), .PSEL(s_psel), .PENABLE(s_penable),
    .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          vcyc;
  } exp_t;
  exp_t sb[$];

  // Slave model: PREADY rises after wait_cfg stalled ACCESS cycles; PRDATA is junk unless PREADY.
  int          wait_cfg = 0;
  logic        setup_rdy = 1'b0;
  logic [31:0] prdata_cfg = '0;
  initial begin
    int acc_n;
    acc_n = 0;
    forever begin
      @(posedge PCLK);
      #1;
      acc_n  = PENABLE ? acc_n + 1 : 0;
      PREADY = (PENABLE && acc_n > wait_cfg) || (!PENABLE && PSEL != 16'h0 && setup_rdy);
      PRDATA = PREADY ? prdata_cfg : 32'hBAD0_BAD0;
    end
  end

  initial begin
    logic prev_v;
    int   rise_cyc;
    exp_t e;
    prev_v   = 1'b0;
    rise_cyc = 0;
    forever begin
      @(negedge PCLK);
      if (rsp_valid === 1'b1 && prev_v !== 1'b1) rise_cyc = cyc;
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rsp_unexpected: got rdata %h err %b with nothing expected", rsp_rdata, rsp_err);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
          chk("rsp_cycle", rise_cyc, e.vcyc);
          chk("psel_in_rsp", 32'(PSEL), 32'h0);
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int wcfg, input logic [31:0] prd, input logic [31:0] exp_rdata,
                        input logic exp_err, input int lat, input logic [15:0] exp_psel,
                        input bit push, output int t0);
    int   guard;
    exp_t e;
    wait_cfg   = wcfg;
    prdata_cfg = prd;
    req_write  = wr;
    req_addr   = addr;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 50) begin
      @(posedge PCLK);
      #1;
      guard++;
    end
    if (req_ready !== 1'b1) chk("req_ready_wait", 32'(req_ready), 32'h1);
    @(posedge PCLK);
    #1;
    req_valid = 1'b0;
    t0 = cyc;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.vcyc  = t0 + lat - 1;
      sb.push_back(e);
    end
    chk("psel_c1", 32'(PSEL), 32'(exp_psel));
    chk("penable_c1", 32'(PENABLE), 32'h0);
    chk("paddr_c1", PADDR, addr);
    chk("pwdata_c1", PWDATA, wdata);
    chk("pwrite_c1", 32'(PWRITE), 32'(wr));
    @(posedge PCLK);
    #1;
    chk("psel_c2", 32'(PSEL), 32'(exp_psel));
    chk("penable_c2", 32'(PENABLE), 32'h1);
    chk("pwdata_c2", PWDATA, wdata);
  endtask

  task automatic finish_xfer(input logic [15:0] exp_psel);
    int g;
    g = 0;
    while (req_ready !== 1'b1 && g < 400) begin
      if (PENABLE === 1'b1) chk("psel_hold", 32'(PSEL), 32'(exp_psel));
      @(posedge PCLK);
      #1;
      g++;
    end
    if (req_ready !== 1'b1) chk("idle_wait", 32'(req_ready), 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int          t0, t1, ck;
    logic [31:0] sa [2];
    sa[0] = 32'h0000_7000;
    sa[1] = 32'h0000_4000;

    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'h1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_psel", 32'(PSEL), 32'h0);
    chk("rst_penable", 32'(PENABLE), 32'h0);
    chk("rst_paddr", PADDR, 32'h0);
    chk("rst_pwdata", PWDATA, 32'h0);
    chk("rst_pwrite", 32'(PWRITE), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    PRESET = 1'b0;
    @(posedge PCLK);
    #1;

    // Zero-wait write: rdata must be 0 even though the slave drives PRDATA.
    do_req(1'b1, 32'h0000_2010, 32'hDEAD_BEEF, 0, 32'hCAFE_F00D, 32'h0, 1'b0, 3, 16'h0004, 1'b1, t0);
    finish_xfer(16'h0004);

    do_req(1'b0, 32'h0000_5000, 32'h0, 3, 32'h1234_5678, 32'h1234_5678, 1'b0, 6, 16'h0020, 1'b1, t0);
    finish_xfer(16'h0020);

    // Top slave; PREADY high during SETUP must not shorten the transfer.
    setup_rdy = 1'b1;
    do_req(1'b0, 32'h0000_F004, 32'h1111_2222, 0, 32'hA5A5_0F0F, 32'hA5A5_0F0F, 1'b0, 3, 16'h8000, 1'b1, t0);
    finish_xfer(16'h8000);
    setup_rdy = 1'b0;
    chk("paddr_idle_kept", PADDR, 32'h0000_F004);

    do_req(1'b1, 32'h0000_1000, 32'h0BEE_F00D, 1, 32'h5555_5555, 32'h0, 1'b0, 4, 16'h0002, 1'b1, t0);
    finish_xfer(16'h0002);

    // Decode errors on the 4-slave instance, including the first unpopulated index.
    for (int i = 0; i < 2; i++) begin
      chk("s_req_ready", 32'(s_req_ready), 32'h1);
      s_req_addr  = sa[i];
      s_req_valid = 1'b1;
      @(posedge PCLK);
      #1;
      s_req_valid = 1'b0;
      chk("s_psel", 32'(s_psel), 32'h0);
      chk("s_penable", 32'(s_penable), 32'h0);
      chk("s_rsp_valid", 32'(s_rsp_valid), 32'h1);
      chk("s_rsp_err", 32'(s_rsp_err), 32'h1);
      chk("s_rsp_rdata", s_rsp_rdata, 32'h0);
      @(posedge PCLK);
      #1;
      chk("s_rsp_valid_pulse", 32'(s_rsp_valid), 32'h0);
    end

    // Response held for 5 cycles with a new request pending.
    rsp_ready = 1'b0;
    do_req(1'b0, 32'h0000_3000, 32'h0, 0, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b0, 3, 16'h0008, 1'b1, t0);
    @(posedge PCLK);
    #1;
    req_write = 1'b1;
    req_addr  = 32'h0000_6008;
    req_wdata = 32'h55AA_55AA;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rsp_rdata", rsp_rdata, 32'h0BAD_CAFE);
      chk("hold_rsp_err", 32'(rsp_err), 32'h0);
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      @(posedge PCLK);
      #1;
    end
    rsp_ready = 1'b1;
    ck = cyc;
    do_req(1'b1, 32'h0000_6008, 32'h55AA_55AA, 0, 32'h7E7E_7E7E, 32'h0, 1'b0, 3, 16'h0040, 1'b1, t1);
    chk("accept_after_rsp", t1, ck + 2);
    finish_xfer(16'h0040);

    // Reset in the middle of ACCESS drops the transfer silently.
    do_req(1'b0, 32'h0000_9000, 32'h0, 20, 32'h0, 32'h0, 1'b0, 0, 16'h0200, 1'b0, t0);
    @(posedge PCLK);
    #1;
    PRESET = 1'b1;
    @(posedge PCLK);
    #1;
    PRESET = 1'b0;
    chk("mrst_psel", 32'(PSEL), 32'h0);
    chk("mrst_penable", 32'(PENABLE), 32'h0);
    chk("mrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("mrst_req_ready", 32'(req_ready), 32'h1);
    do_req(1'b0, 32'h0000_A000, 32'h0, 2, 32'h600D_F00D, 32'h600D_F00D, 1'b0, 5, 16'h0400, 1'b1, t0);
    finish_xfer(16'h0400);

`ifdef APB_MASTER_TIMEOUT_EN
    do_req(1'b0, 32'h0000_B000, 32'h0, 1000, 32'h9999_9999, 32'h0, 1'b1, 10, 16'h0800, 1'b1, t0);
    finish_xfer(16'h0800);
    do_req(1'b0, 32'h0000_B000, 32'h0, 7, 32'h7777_0001, 32'h7777_0001, 1'b0, 10, 16'h0800, 1'b1, t0);
    finish_xfer(16'h0800);
`endif

    repeat (3) @(posedge PCLK);
    #1;
    chk("sb_drained", sb.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
